// File: rtl/vanilla_scoreboard_stall_profiler.sv
// Attributes ID-stage dependency stalls to the outstanding operation class blocking the operand,
// keeps saturating per-class counters plus the longest stall episode, and streams a snapshot on request.
module vanilla_scoreboard_stall_profiler #(
    parameter int ctr_width_p      = 32,
    parameter int reg_els_p        = 32,
    parameter int reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [4*reg_els_p-1:0]      int_sb_i,
    input  logic [4*reg_els_p-1:0]      float_sb_i,
    input  logic                        stall_depend_i,
    input  logic                        stall_all_i,
    input  logic [reg_addr_width_p-1:0] rs1_i,
    input  logic [reg_addr_width_p-1:0] rs2_i,
    input  logic                        rs1_v_i,
    input  logic                        rs2_v_i,
    input  logic [reg_addr_width_p-1:0] frs1_i,
    input  logic [reg_addr_width_p-1:0] frs2_i,
    input  logic [reg_addr_width_p-1:0] frs3_i,
    input  logic                        frs1_v_i,
    input  logic                        frs2_v_i,
    input  logic                        frs3_v_i,
    input  logic [reg_addr_width_p-1:0] rd_i,
    input  logic                        rd_int_v_i,
    input  logic                        rd_fp_v_i,
    input  logic                        dump_v_i,
    output logic                        busy_o,
    output logic                        data_v_o,
    input  logic                        data_ready_i,
    output logic [3:0]                  data_idx_o,
    output logic [ctr_width_p-1:0]      data_o
);

    localparam int num_ctr_lp   = 9;
    localparam int num_words_lp = 10;
    localparam logic [ctr_width_p-1:0] one_lp = {{(ctr_width_p-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, DUMP} state_e;

    function automatic logic [ctr_width_p-1:0] sat_inc(input logic [ctr_width_p-1:0] v);
        return (&v) ? v : v + one_lp;
    endfunction

    logic [3:0] int_ent [reg_els_p];
    logic [3:0] fp_ent  [reg_els_p];

    for (genvar g = 0; g < reg_els_p; g++) begin : g_ent
        assign int_ent[g] = int_sb_i[4*g +: 4];
        assign fp_ent[g]  = float_sb_i[4*g +: 4];
    end

    logic [3:0] ihz, fhz;
    logic [3:0] hz_sel;
    logic       count_event;

    assign ihz = (rs1_v_i    ? int_ent[rs1_i] : 4'b0)
               | (rs2_v_i    ? int_ent[rs2_i] : 4'b0)
               | (rd_int_v_i ? int_ent[rd_i]  : 4'b0);

    assign fhz = (frs1_v_i  ? fp_ent[frs1_i] : 4'b0)
               | (frs2_v_i  ? fp_ent[frs2_i] : 4'b0)
               | (frs3_v_i  ? fp_ent[frs3_i] : 4'b0)
               | (rd_fp_v_i ? fp_ent[rd_i]   : 4'b0);

    // A frozen pipe is not a dependency stall, so it neither counts nor extends an episode.
    assign count_event = stall_depend_i & ~stall_all_i;

    always_comb begin
        hz_sel = 4'd8;
        if      (ihz[3]) hz_sel = 4'd0;
        else if (ihz[2]) hz_sel = 4'd1;
        else if (ihz[1]) hz_sel = 4'd2;
        else if (ihz[0]) hz_sel = 4'd3;
        else if (fhz[3]) hz_sel = 4'd4;
        else if (fhz[2]) hz_sel = 4'd5;
        else if (fhz[1]) hz_sel = 4'd6;
        else if (fhz[0]) hz_sel = 4'd7;
    end

    logic [ctr_width_p-1:0] ctr_r  [num_ctr_lp];
    logic [ctr_width_p-1:0] ctr_n  [num_ctr_lp];
    logic [ctr_width_p-1:0] snap_r [num_words_lp];
    logic [ctr_width_p-1:0] ep_len_r, ep_inc, ep_len_n;
    logic [ctr_width_p-1:0] max_ep_r, max_ep_n;

    state_e     state_r, state_n;
    logic [3:0] idx_r;
    logic       dump_start;

    assign dump_start = (state_r == IDLE) && dump_v_i;

    always_comb begin
        for (int k = 0; k < num_ctr_lp; k++) begin
            ctr_n[k] = (count_event && hz_sel == 4'(k)) ? sat_inc(ctr_r[k]) : ctr_r[k];
        end
        ep_inc   = sat_inc(ep_len_r);
        ep_len_n = count_event ? ep_inc : '0;
        max_ep_n = (count_event && ep_inc > max_ep_r) ? ep_inc : max_ep_r;
    end

    // The dump cycle's own event lands in the snapshot while the live state restarts from zero.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < num_ctr_lp; k++) ctr_r[k] <= '0;
            ep_len_r <= '0;
            max_ep_r <= '0;
        end else if (dump_start) begin
            for (int k = 0; k < num_ctr_lp; k++) ctr_r[k] <= '0;
            ep_len_r <= '0;
            max_ep_r <= '0;
        end else begin
            for (int k = 0; k < num_ctr_lp; k++) ctr_r[k] <= ctr_n[k];
            ep_len_r <= ep_len_n;
            max_ep_r <= max_ep_n;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < num_words_lp; k++) snap_r[k] <= '0;
        end else if (dump_start) begin
            for (int k = 0; k < num_ctr_lp; k++) snap_r[k] <= ctr_n[k];
            snap_r[9] <= max_ep_n;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idx_r <= 4'd0;
        end else if (dump_start) begin
            idx_r <= 4'd0;
        end else if (state_r == DUMP && data_ready_i) begin
            idx_r <= (idx_r == 4'd9) ? 4'd0 : idx_r + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= IDLE;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (dump_v_i) state_n = DUMP;
            DUMP:    if (data_ready_i && idx_r == 4'd9) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = 1'b0;
        data_v_o   = 1'b0;
        data_idx_o = idx_r;
        data_o     = '0;
        if (state_r == DUMP) begin
            busy_o   = 1'b1;
            data_v_o = 1'b1;
            data_o   = snap_r[idx_r];
        end
    end

endmodule

// File: tb/tb_vanilla_scoreboard_stall_profiler.sv
// Scoreboard bench: expected dump words are queued when a dump is requested; monitors pop on acceptance.
// A second instance with 4-bit counters shares every input and expects the same words clipped to 15.
module tb_vanilla_scoreboard_stall_profiler;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [127:0] int_sb_i, float_sb_i;
    logic         stall_depend_i, stall_all_i;
    logic [4:0]   rs1_i, rs2_i, frs1_i, frs2_i, frs3_i, rd_i;
    logic         rs1_v_i, rs2_v_i, frs1_v_i, frs2_v_i, frs3_v_i, rd_int_v_i, rd_fp_v_i;
    logic         dump_v_i, data_ready_i;

    logic         busy_o, data_v_o;
    logic [3:0]   data_idx_o;
    logic [31:0]  data_o;
    logic         busy_n, data_v_n;
    logic [3:0]   data_idx_n;
    logic [3:0]   data_n;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } word_t;

    word_t       expQ[$];
    word_t       expQN[$];
    logic [31:0] expWords [10];
    int          total = 0;
    int          bad = 0;
    int          acceptedMain = 0;
    int          acceptedNarrow = 0;

    always #5 clk_i = ~clk_i;

    vanilla_scoreboard_stall_profiler dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .int_sb_i(int_sb_i), .float_sb_i(float_sb_i),
        .stall_depend_i(stall_depend_i), .stall_all_i(stall_all_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_v_i(rs1_v_i), .rs2_v_i(rs2_v_i),
        .frs1_i(frs1_i), .frs2_i(frs2_i), .frs3_i(frs3_i),
        .frs1_v_i(frs1_v_i), .frs2_v_i(frs2_v_i), .frs3_v_i(frs3_v_i),
        .rd_i(rd_i), .rd_int_v_i(rd_int_v_i), .rd_fp_v_i(rd_fp_v_i),
        .dump_v_i(dump_v_i), .busy_o(busy_o), .data_v_o(data_v_o),
        .data_ready_i(data_ready_i), .data_idx_o(data_idx_o), .data_o(data_o)
    );

    vanilla_scoreboard_stall_profiler #(.ctr_width_p(4)) dut_narrow (
        .clk_i(clk_i), .reset_i(reset_i),
        .int_sb_i(int_sb_i), .float_sb_i(float_sb_i),
        .stall_depend_i(stall_depend_i), .stall_all_i(stall_all_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_v_i(rs1_v_i), .rs2_v_i(rs2_v_i),
        .frs1_i(frs1_i), .frs2_i(frs2_i), .frs3_i(frs3_i),
        .frs1_v_i(frs1_v_i), .frs2_v_i(frs2_v_i), .frs3_v_i(frs3_v_i),
        .rd_i(rd_i), .rd_int_v_i(rd_int_v_i), .rd_fp_v_i(rd_fp_v_i),
        .dump_v_i(dump_v_i), .busy_o(busy_n), .data_v_o(data_v_n),
        .data_ready_i(data_ready_i), .data_idx_o(data_idx_n), .data_o(data_n)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (!reset_i && data_v_o) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL main_extra_word actual idx=%0d required=no word", data_idx_o);
            end else begin
                checkOutput("main_idx", 32'(data_idx_o), 32'(expQ[0].idx));
                checkOutput("main_data", data_o, expQ[0].data);
                if (data_ready_i) begin
                    expQ.delete(0);
                    acceptedMain++;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (!reset_i && data_v_n) begin
            if (expQN.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL narrow_extra_word actual idx=%0d required=no word", data_idx_n);
            end else begin
                checkOutput("narrow_idx", 32'(data_idx_n), 32'(expQN[0].idx));
                checkOutput("narrow_data", 32'(data_n), expQN[0].data);
                if (data_ready_i) begin
                    expQN.delete(0);
                    acceptedNarrow++;
                end
            end
        end
    end

    task automatic clearAll();
        int_sb_i = '0; float_sb_i = '0;
        stall_depend_i = 0; stall_all_i = 0;
        rs1_i = 0; rs2_i = 0; frs1_i = 0; frs2_i = 0; frs3_i = 0; rd_i = 0;
        rs1_v_i = 0; rs2_v_i = 0; frs1_v_i = 0; frs2_v_i = 0; frs3_v_i = 0;
        rd_int_v_i = 0; rd_fp_v_i = 0;
    endtask

    task automatic setInt(input int idx, input logic [3:0] v);
        int_sb_i[4*idx +: 4] = v;
    endtask

    task automatic setFp(input int idx, input logic [3:0] v);
        float_sb_i[4*idx +: 4] = v;
    endtask

    task automatic applyStimulus(input int n, input logic dep, input logic all);
        stall_depend_i = dep;
        stall_all_i    = all;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic clearExp();
        for (int k = 0; k < 10; k++) expWords[k] = 0;
    endtask

    task automatic pushDump();
        word_t w;
        for (int k = 0; k < 10; k++) begin
            w.idx  = 4'(k);
            w.data = expWords[k];
            expQ.push_back(w);
            w.data = (expWords[k] > 32'd15) ? 32'd15 : expWords[k];
            expQN.push_back(w);
        end
    endtask

    task automatic startDump();
        acceptedMain   = 0;
        acceptedNarrow = 0;
        dump_v_i = 1;
        @(posedge clk_i);
        #1;
        dump_v_i = 0;
    endtask

    task automatic drainDump(input logic [3:0] pat);
        int i = 0;
        while (busy_o && i < 200) begin
            data_ready_i = pat[i[1:0]];
            @(posedge clk_i);
            #1;
            i++;
        end
        data_ready_i = 0;
        if (i >= 200) begin
            total++;
            bad++;
            $display("[TB] FAIL dump_timeout actual=busy required=idle");
        end
        checkOutput("main_accepted", 32'(acceptedMain), 32'd10);
        checkOutput("narrow_accepted", 32'(acceptedNarrow), 32'd10);
    endtask

    initial begin
        int i;
        clearAll();
        dump_v_i = 0;
        data_ready_i = 0;
        reset_i = 1;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 0;
        checkOutput("reset_busy", 32'(busy_o), 0);
        checkOutput("reset_valid", 32'(data_v_o), 0);
        checkOutput("reset_idx", 32'(data_idx_o), 0);
        checkOutput("reset_data", data_o, 0);
        checkOutput("reset_narrow_busy", 32'(busy_n), 0);

        $display("[TB] idiv on rs1, 7 stall cycles");
        setInt(5, 4'b1000); rs1_i = 5; rs1_v_i = 1;
        applyStimulus(7, 1, 0);
        applyStimulus(1, 0, 0);
        clearExp(); expWords[0] = 7; expWords[9] = 7; pushDump();
        startDump();
        drainDump(4'b1111);

        $display("[TB] priority: ihz=0101 beats fhz fdiv");
        clearAll();
        setInt(5, 4'b0101); rs1_i = 5; rs1_v_i = 1;
        setFp(2, 4'b1000); frs2_i = 2; frs2_v_i = 1;
        applyStimulus(3, 1, 0);
        applyStimulus(1, 0, 0);
        clearExp(); expWords[1] = 3; expWords[9] = 3; pushDump();
        startDump();
        drainDump(4'b1111);

        $display("[TB] WAW destinations and frs3");
        clearAll();
        setInt(9, 4'b0001); rd_i = 9; rd_int_v_i = 1;
        applyStimulus(2, 1, 0);
        applyStimulus(1, 0, 0);
        rd_int_v_i = 0; rd_fp_v_i = 1; setFp(9, 4'b0100);
        applyStimulus(3, 1, 0);
        applyStimulus(1, 0, 0);
        rd_fp_v_i = 0; setFp(4, 4'b0001); frs3_i = 4; frs3_v_i = 1;
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        clearExp(); expWords[3] = 2; expWords[5] = 3; expWords[7] = 1; expWords[9] = 3; pushDump();
        startDump();
        drainDump(4'b1111);

        $display("[TB] unattributed stalls");
        clearAll();
        applyStimulus(4, 1, 0);
        applyStimulus(1, 0, 0);
        clearExp(); expWords[8] = 4; expWords[9] = 4; pushDump();
        startDump();
        drainDump(4'b1111);

        $display("[TB] stall_all splits episode, dump under backpressure");
        applyStimulus(2, 1, 0);
        applyStimulus(1, 1, 1);
        applyStimulus(3, 1, 0);
        applyStimulus(1, 0, 0);
        clearExp(); expWords[8] = 5; expWords[9] = 3; pushDump();
        startDump();
        drainDump(4'b1001);

        $display("[TB] dump coinciding with a count event");
        clearAll();
        setFp(7, 4'b0010); frs1_i = 7; frs1_v_i = 1;
        data_ready_i = 1;
        applyStimulus(9, 1, 0);
        clearExp(); expWords[6] = 10; expWords[9] = 10; pushDump();
        acceptedMain = 0;
        acceptedNarrow = 0;
        dump_v_i = 1;
        applyStimulus(1, 1, 0);
        dump_v_i = 0;
        applyStimulus(1, 1, 0);
        stall_depend_i = 0;
        drainDump(4'b1111);
        clearExp(); expWords[6] = 1; expWords[9] = 1; pushDump();
        startDump();
        drainDump(4'b1111);

        $display("[TB] saturation with 20 idiv events");
        clearAll();
        setInt(3, 4'b1000); rs2_i = 3; rs2_v_i = 1;
        applyStimulus(20, 1, 0);
        applyStimulus(1, 0, 0);
        clearExp(); expWords[0] = 20; expWords[9] = 20; pushDump();
        startDump();
        drainDump(4'b1111);

        $display("[TB] reset in the middle of a dump");
        applyStimulus(3, 1, 0);
        applyStimulus(1, 0, 0);
        clearExp(); expWords[0] = 3; expWords[9] = 3; pushDump();
        data_ready_i = 1;
        startDump();
        i = 0;
        while (!(data_v_o && data_idx_o == 4'd4) && i < 50) begin
            @(negedge clk_i);
            i++;
        end
        if (i >= 50) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_idx4 actual=idx %0d required=idx 4", data_idx_o);
        end
        #2 reset_i = 1;
        #1;
        checkOutput("midreset_busy", 32'(busy_o), 0);
        checkOutput("midreset_valid", 32'(data_v_o), 0);
        checkOutput("midreset_narrow_busy", 32'(busy_n), 0);
        checkOutput("midreset_narrow_valid", 32'(data_v_n), 0);
        expQ.delete();
        expQN.delete();
        data_ready_i = 0;
        @(posedge clk_i);
        #1 reset_i = 0;
        checkOutput("postreset_idx", 32'(data_idx_o), 0);
        checkOutput("postreset_data", data_o, 0);
        clearExp(); pushDump();
        startDump();
        drainDump(4'b1111);

        applyStimulus(2, 0, 0);
        checkOutput("main_queue_empty", 32'(expQ.size()), 0);
        checkOutput("narrow_queue_empty", 32'(expQN.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
